phy_os_rcvr: RTL and testbench

Receive-side ordered-set (OS) parser for the PHY's training path. It consumes the MAC-to-PHY byte stream and assembles COM-aligned ordered sets into a 16-byte queue. It classifies each completed set as TS1, TS2, SKP or NONE, latches TS1/TS2 fields, and counts received TS1s and TS2s. The LTSSM uses these outputs for link training decisions.

---
 rtl/ozphy_pkg.sv | 39 +++
 rtl/os_classifier.sv | 33 +++
 rtl/phy_os_rcvr.sv | 148 ++++++++++++++
 tb/tb_phy_os_rcvr.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ozphy_pkg.sv
// Shared types and symbol constants for the PHY training-path ordered-set receiver.
package ozphy_pkg;

    localparam int TS_LEN  = 16;
    localparam int SKP_LEN = 4;

    localparam logic [7:0] COM   = 8'hBC;
    localparam logic [7:0] SKP   = 8'h1C;
    localparam logic [7:0] PAD   = 8'hF7;
    localparam logic [7:0] TS1ID = 8'h4A;
    localparam logic [7:0] TS2ID = 8'h45;

    typedef enum logic [3:0] {
        DETECT_QUIET,
        DETECT_ACTIVE,
        POLLING_ACTIVE,
        POLLING_CONFIG,
        CONFIG_LINKWIDTH_START,
        CONFIG_LINKWIDTH_ACCEPT,
        CONFIG_LANENUM_WAIT,
        CONFIG_LANENUM_ACCEPT,
        CONFIG_COMPLETE,
        CONFIG_IDLE,
        L0,
        RECOVERY
    } ltssm_state_t;

    typedef enum logic [1:0] {OS_NONE, OS_SKP, OS_TS1, OS_TS2} os_type_t;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } os_sym_t;

    function automatic logic is_sym(input os_sym_t s, input logic k, input logic [7:0] d);
        return (s.k == k) && (s.data == d);
    endfunction

endpackage

// File: rtl/os_classifier.sv
// Combinational ordered-set classifier over a COM-aligned symbol queue.
module os_classifier
    import ozphy_pkg::*;
#(
    parameter int LEN = TS_LEN
) (
    input  os_sym_t [LEN-1:0] q,
    output os_type_t          os_type
);

    logic skp_hit;
    logic ts1_hit;
    logic ts2_hit;

    always_comb begin
        skp_hit = 1'b1;
        ts1_hit = 1'b1;
        ts2_hit = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            if (!is_sym(q[i], 1'b1, SKP)) skp_hit = 1'b0;
        end
        for (int i = 6; i < LEN; i++) begin
            if (!is_sym(q[i], 1'b0, TS1ID)) ts1_hit = 1'b0;
            if (!is_sym(q[i], 1'b0, TS2ID)) ts2_hit = 1'b0;
        end

        if (skp_hit)      os_type = OS_SKP;
        else if (ts1_hit) os_type = OS_TS1;
        else if (ts2_hit) os_type = OS_TS2;
        else              os_type = OS_NONE;
    end

endmodule

// File: rtl/phy_os_rcvr.sv
// Receive-side ordered-set parser: assembles COM-aligned sets, classifies them,
// latches TS1/TS2 fields and keeps per-type training-set counters.
module phy_os_rcvr
    import ozphy_pkg::*;
#(
    parameter int MAX_TS_LEN = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   txdata,
    input  logic         txdatak,
    input  logic         en_n,
    input  ltssm_state_t curr_ltssm_state,
    output logic         os_valid,
    output os_type_t     os_type,
    output logic [7:0]   ts1_linkn,
    output logic [7:0]   ts1_lanen,
    output logic [7:0]   ts1_nfts,
    output logic [7:0]   ts1_dri,
    output logic [7:0]   ts1_tc,
    output logic [7:0]   ts2_linkn,
    output logic [7:0]   ts2_lanen,
    output logic [7:0]   ts2_nfts,
    output logic [7:0]   ts2_dri,
    output logic [7:0]   ts2_tc,
    output logic [15:0]  ts1ctr,
    output logic [15:0]  ts2ctr,
    output logic         link_proposed
);

    localparam int PTR_W = $clog2(MAX_TS_LEN + 1);
    localparam int IDX_W = $clog2(MAX_TS_LEN);
    localparam logic [PTR_W-1:0] LEN_TS  = PTR_W'(MAX_TS_LEN);
    localparam logic [PTR_W-1:0] LEN_SKP = PTR_W'(SKP_LEN);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    os_sym_t [MAX_TS_LEN-1:0] q, q_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] len, len_nxt;
    ltssm_state_t     prev_state;
    os_sym_t          sym;
    logic             is_com;
    logic             wr;
    logic             complete;
    logic             state_chg;
    os_type_t         cls;
    logic [15:0]      ts1_base, ts2_base, ts1_nxt, ts2_nxt;
    logic             lp_nxt;

    assign sym    = '{k: txdatak, data: txdata};
    assign is_com = txdatak && (txdata == COM);

    // queue write / frame restart
    always_comb begin
        q_nxt   = q;
        ptr_nxt = ptr;
        len_nxt = len;
        wr      = 1'b0;
        if (!en_n) begin
            if (is_com) begin
                q_nxt    = '0;
                q_nxt[0] = sym;
                ptr_nxt  = PTR_W'(1);
                len_nxt  = LEN_TS;
            end else if ((ptr != '0) && (ptr < len)) begin
                q_nxt[ptr[IDX_W-1:0]] = sym;
                ptr_nxt = ptr + PTR_W'(1);
                wr      = 1'b1;
                // Entry 1 decides whether this is a short SKP set.
                if (ptr == PTR_W'(1)) begin
                    len_nxt = is_sym(sym, 1'b1, SKP) ? LEN_SKP : LEN_TS;
                end
            end
        end
    end

    assign complete = wr && (ptr_nxt == len_nxt);

    os_classifier #(.LEN(MAX_TS_LEN)) u_cls (
        .q       (q_nxt),
        .os_type (cls)
    );

    // Counter clear takes effect before the count on the same edge.
    always_comb begin
        state_chg = (curr_ltssm_state != prev_state);
        ts1_base  = (state_chg || (complete && cls == OS_TS2)) ? 16'd0 : ts1ctr;
        ts2_base  = (state_chg || (complete && cls == OS_TS1)) ? 16'd0 : ts2ctr;
        ts1_nxt   = (complete && cls == OS_TS1) ? sat_inc(ts1_base) : ts1_base;
        ts2_nxt   = (complete && cls == OS_TS2) ? sat_inc(ts2_base) : ts2_base;
        lp_nxt    = complete && (cls == OS_TS1) && !is_sym(q_nxt[1], 1'b1, PAD)
                    && (curr_ltssm_state == CONFIG_LINKWIDTH_START);
    end

    // completion register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            q             <= '0;
            ptr           <= '0;
            len           <= LEN_TS;
            os_valid      <= 1'b0;
            os_type       <= OS_NONE;
            ts1_linkn     <= '0;
            ts1_lanen     <= '0;
            ts1_nfts      <= '0;
            ts1_dri       <= '0;
            ts1_tc        <= '0;
            ts2_linkn     <= '0;
            ts2_lanen     <= '0;
            ts2_nfts      <= '0;
            ts2_dri       <= '0;
            ts2_tc        <= '0;
            ts1ctr        <= '0;
            ts2ctr        <= '0;
            link_proposed <= 1'b0;
        end else begin
            q             <= q_nxt;
            ptr           <= ptr_nxt;
            len           <= len_nxt;
            os_valid      <= complete;
            ts1ctr        <= ts1_nxt;
            ts2ctr        <= ts2_nxt;
            link_proposed <= lp_nxt;
            if (complete) begin
                os_type <= cls;
                if (cls == OS_TS1) begin
                    ts1_linkn <= q_nxt[1].data;
                    ts1_lanen <= q_nxt[2].data;
                    ts1_nfts  <= q_nxt[3].data;
                    ts1_dri   <= q_nxt[4].data;
                    ts1_tc    <= q_nxt[5].data;
                end else if (cls == OS_TS2) begin
                    ts2_linkn <= q_nxt[1].data;
                    ts2_lanen <= q_nxt[2].data;
                    ts2_nfts  <= q_nxt[3].data;
                    ts2_dri   <= q_nxt[4].data;
                    ts2_tc    <= q_nxt[5].data;
                end
            end
        end
        // Tracks the input even in reset so no spurious clear follows reset.
        prev_state <= curr_ltssm_state;
    end

endmodule

// File: tb/tb_phy_os_rcvr.sv
// Randomized self-checking bench for phy_os_rcvr against a frame-level queue model.
module tb_phy_os_rcvr;
    import ozphy_pkg::*;

    typedef os_sym_t sym_q_t[$];

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   txdata;
    logic         txdatak;
    logic         en_n;
    ltssm_state_t st;
    logic         os_valid;
    os_type_t     os_type;
    logic [7:0]   ts1_linkn, ts1_lanen, ts1_nfts, ts1_dri, ts1_tc;
    logic [7:0]   ts2_linkn, ts2_lanen, ts2_nfts, ts2_dri, ts2_tc;
    logic [15:0]  ts1ctr, ts2ctr;
    logic         link_proposed;

    always #5 clk = ~clk;

    phy_os_rcvr #(.MAX_TS_LEN(16)) dut (
        .clk(clk), .reset(reset), .txdata(txdata), .txdatak(txdatak), .en_n(en_n),
        .curr_ltssm_state(st), .os_valid(os_valid), .os_type(os_type),
        .ts1_linkn(ts1_linkn), .ts1_lanen(ts1_lanen), .ts1_nfts(ts1_nfts),
        .ts1_dri(ts1_dri), .ts1_tc(ts1_tc),
        .ts2_linkn(ts2_linkn), .ts2_lanen(ts2_lanen), .ts2_nfts(ts2_nfts),
        .ts2_dri(ts2_dri), .ts2_tc(ts2_tc),
        .ts1ctr(ts1ctr), .ts2ctr(ts2ctr), .link_proposed(link_proposed)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int pulses = 0;
    int lp_cnt = 0;

    // reference model state
    os_sym_t      frame[$];
    logic         m_valid, m_lp;
    os_type_t     m_type;
    logic [7:0]   m_ts1[5], m_ts2[5];
    logic [15:0]  m_c1, m_c2;
    ltssm_state_t m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int m_len();
        if (frame.size() >= 2 && frame[1].k && frame[1].data == SKP) return 4;
        return 16;
    endfunction

    function automatic os_type_t m_class();
        bit skp = 1, t1 = 1, t2 = 1;
        for (int i = 1; i <= 3; i++)
            if (!(frame[i].k == 1'b1 && frame[i].data == SKP)) skp = 0;
        if (frame.size() < 16) begin
            t1 = 0;
            t2 = 0;
        end else begin
            for (int i = 6; i < 16; i++) begin
                if (frame[i].k || frame[i].data != TS1ID) t1 = 0;
                if (frame[i].k || frame[i].data != TS2ID) t2 = 0;
            end
        end
        if (skp) return OS_SKP;
        if (t1)  return OS_TS1;
        if (t2)  return OS_TS2;
        return OS_NONE;
    endfunction

    task automatic model(input logic r, input logic e, input logic k, input logic [7:0] d);
        bit comp = 0;
        os_type_t c = OS_NONE;
        bit clr;
        if (r) begin
            frame.delete();
            m_valid = 0; m_lp = 0; m_type = OS_NONE; m_c1 = 0; m_c2 = 0;
            for (int i = 0; i < 5; i++) begin m_ts1[i] = 0; m_ts2[i] = 0; end
            m_prev = st;
            return;
        end
        if (!e) begin
            if (k && d == COM) begin
                frame.delete();
                frame.push_back('{k: 1'b1, data: COM});
            end else if (frame.size() > 0 && frame.size() < m_len()) begin
                frame.push_back('{k: k, data: d});
                if (frame.size() == m_len()) comp = 1;
            end
        end
        clr = (st != m_prev);
        if (comp) c = m_class();
        if (clr || (comp && c == OS_TS2)) m_c1 = 0;
        if (clr || (comp && c == OS_TS1)) m_c2 = 0;
        if (comp && c == OS_TS1 && m_c1 != 16'hFFFF) m_c1++;
        if (comp && c == OS_TS2 && m_c2 != 16'hFFFF) m_c2++;
        m_valid = comp;
        m_lp = comp && c == OS_TS1 && !(frame[1].k && frame[1].data == PAD)
               && st == CONFIG_LINKWIDTH_START;
        if (comp) begin
            m_type = c;
            for (int i = 0; i < 5; i++) begin
                if (c == OS_TS1) m_ts1[i] = frame[i+1].data;
                if (c == OS_TS2) m_ts2[i] = frame[i+1].data;
            end
        end
        m_prev = st;
    endtask

    task automatic compare_all();
        check("os_valid", 32'(os_valid), 32'(m_valid));
        check("os_type", 32'(os_type), 32'(m_type));
        check("link_proposed", 32'(link_proposed), 32'(m_lp));
        check("ts1ctr", 32'(ts1ctr), 32'(m_c1));
        check("ts2ctr", 32'(ts2ctr), 32'(m_c2));
        check("ts1_linkn", 32'(ts1_linkn), 32'(m_ts1[0]));
        check("ts1_lanen", 32'(ts1_lanen), 32'(m_ts1[1]));
        check("ts1_nfts", 32'(ts1_nfts), 32'(m_ts1[2]));
        check("ts1_dri", 32'(ts1_dri), 32'(m_ts1[3]));
        check("ts1_tc", 32'(ts1_tc), 32'(m_ts1[4]));
        check("ts2_linkn", 32'(ts2_linkn), 32'(m_ts2[0]));
        check("ts2_lanen", 32'(ts2_lanen), 32'(m_ts2[1]));
        check("ts2_nfts", 32'(ts2_nfts), 32'(m_ts2[2]));
        check("ts2_dri", 32'(ts2_dri), 32'(m_ts2[3]));
        check("ts2_tc", 32'(ts2_tc), 32'(m_ts2[4]));
    endtask

    task automatic step(input logic r, input logic e, input logic k, input logic [7:0] d);
        reset = r; en_n = e; txdatak = k; txdata = d;
        model(r, e, k, d);
        @(posedge clk);
        #1;
        compare_all();
        if (os_valid === 1'b1) pulses++;
        if (link_proposed === 1'b1) lp_cnt++;
        @(negedge clk);
    endtask

    function automatic sym_q_t mk_ts(input logic [7:0] id, input logic lk, input logic [7:0] link,
                                     input logic [7:0] lane, input logic [7:0] nfts,
                                     input logic [7:0] dri, input logic [7:0] tc);
        sym_q_t f;
        f.push_back('{k: 1'b1, data: COM});
        f.push_back('{k: lk, data: link});
        f.push_back('{k: 1'b0, data: lane});
        f.push_back('{k: 1'b0, data: nfts});
        f.push_back('{k: 1'b0, data: dri});
        f.push_back('{k: 1'b0, data: tc});
        for (int i = 0; i < 10; i++) f.push_back('{k: 1'b0, data: id});
        return f;
    endfunction

    function automatic sym_q_t mk_skp();
        sym_q_t f;
        f.push_back('{k: 1'b1, data: COM});
        for (int i = 0; i < 3; i++) f.push_back('{k: 1'b1, data: SKP});
        return f;
    endfunction

    task automatic send(input sym_q_t f, input int gap_max, input bit chg, input ltssm_state_t last_st);
        foreach (f[i]) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) step(1'b0, 1'b1, 1'($urandom), 8'($urandom));
            if (chg && i == f.size() - 1) st = last_st;
            step(1'b0, 1'b0, f[i].k, f[i].data);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        sym_q_t f;
        st = DETECT_QUIET;
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("rst_type", 32'(os_type), 32'(OS_NONE));
        check("rst_ts1ctr", 32'(ts1ctr), 32'd0);
        idle(2);

        // Valid TS1, contiguous
        st = POLLING_ACTIVE;
        idle(1);
        send(mk_ts(TS1ID, 1'b0, 8'h01, 8'h00, 8'h18, 8'h02, 8'h00), 0, 1'b0, st);
        check("tp1_type", 32'(os_type), 32'(OS_TS1));
        check("tp1_linkn", 32'(ts1_linkn), 32'h01);
        check("tp1_nfts", 32'(ts1_nfts), 32'h18);
        check("tp1_ctr", 32'(ts1ctr), 32'd1);

        // Four PAD-link TS1s then one proposing link 5
        st = CONFIG_LINKWIDTH_START;
        idle(1);
        lp_cnt = 0;
        repeat (4) send(mk_ts(TS1ID, 1'b1, PAD, 8'h00, 8'h18, 8'h02, 8'h00), 0, 1'b0, st);
        check("tp2_lp_pad", 32'(lp_cnt), 32'd0);
        send(mk_ts(TS1ID, 1'b0, 8'h05, 8'h00, 8'h18, 8'h02, 8'h00), 0, 1'b0, st);
        check("tp2_ctr", 32'(ts1ctr), 32'd5);
        check("tp2_lp", 32'(lp_cnt), 32'd1);

        // SKP then TS2
        send(mk_skp(), 1, 1'b0, st);
        check("tp3_skp", 32'(os_type), 32'(OS_SKP));
        check("tp3_ctr_keep", 32'(ts1ctr), 32'd5);
        send(mk_ts(TS2ID, 1'b0, 8'h05, 8'h01, 8'h20, 8'h02, 8'h00), 0, 1'b0, st);
        check("tp3_ts2ctr", 32'(ts2ctr), 32'd1);
        check("tp3_ts1ctr", 32'(ts1ctr), 32'd0);

        // Interrupted frame, back-to-back then with gaps
        for (int gap = 0; gap <= 3; gap += 3) begin
            pulses = 0;
            f = mk_ts(TS1ID, 1'b0, 8'h02, 8'h03, 8'h10, 8'h02, 8'h00);
            while (f.size() > 10) void'(f.pop_back());
            send(f, gap, 1'b0, st);
            send(mk_ts(TS1ID, 1'b0, 8'h02, 8'h03, 8'h10, 8'h02, 8'h00), gap, 1'b0, st);
            check("tp4_pulses", 32'(pulses), 32'd1);
        end

        // Counter clear on state change, and clear+count on one edge
        st = CONFIG_LINKWIDTH_ACCEPT;
        idle(1);
        repeat (3) send(mk_ts(TS1ID, 1'b0, 8'h01, 8'h01, 8'h08, 8'h02, 8'h00), 0, 1'b0, st);
        check("tp5_three", 32'(ts1ctr), 32'd3);
        st = CONFIG_LANENUM_WAIT;
        idle(1);
        check("tp5_clr", 32'(ts1ctr), 32'd0);
        repeat (2) send(mk_ts(TS1ID, 1'b0, 8'h01, 8'h01, 8'h08, 8'h02, 8'h00), 0, 1'b0, st);
        send(mk_ts(TS1ID, 1'b0, 8'h01, 8'h01, 8'h08, 8'h02, 8'h00), 0, 1'b1, CONFIG_LANENUM_ACCEPT);
        check("tp5_clr_cnt", 32'(ts1ctr), 32'd1);

        // Reset in the middle of a TS2
        pulses = 0;
        f = mk_ts(TS2ID, 1'b0, 8'h07, 8'h00, 8'h30, 8'h02, 8'h00);
        while (f.size() > 8) void'(f.pop_back());
        send(f, 0, 1'b0, st);
        step(1'b1, 1'b0, 1'b0, TS2ID);
        idle(2);
        check("tp6_no_pulse", 32'(pulses), 32'd0);
        check("tp6_ts1ctr", 32'(ts1ctr), 32'd0);
        check("tp6_type", 32'(os_type), 32'(OS_NONE));
        send(mk_ts(TS2ID, 1'b0, 8'h07, 8'h00, 8'h30, 8'h02, 8'h00), 0, 1'b0, st);
        check("tp6_ts2ctr", 32'(ts2ctr), 32'd1);
        check("tp6_linkn", 32'(ts2_linkn), 32'h07);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            int kind;
            logic lk;
            logic [7:0] lnk;
            kind = int'($urandom_range(5, 0));
            lk   = ($urandom_range(3, 0) == 0);
            lnk  = lk ? PAD : 8'($urandom);
            if ($urandom_range(7, 0) == 0)
                st = ($urandom_range(1, 0) == 0) ? CONFIG_LINKWIDTH_START
                                                 : ltssm_state_t'($urandom_range(11, 0));
            case (kind)
                0: f = mk_ts(TS1ID, lk, lnk, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                1: f = mk_ts(TS2ID, lk, lnk, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                2: f = mk_skp();
                3: begin
                    int idx;
                    f = mk_ts(($urandom_range(1, 0) == 0) ? TS1ID : TS2ID, lk, lnk,
                              8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                    idx = int'($urandom_range(15, 1));
                    if ($urandom_range(1, 0) == 0) f[idx].k = 1'b1;
                    else f[idx].data = f[idx].data ^ 8'h01;
                end
                4: begin
                    f = mk_ts(TS1ID, lk, lnk, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                    repeat ($urandom_range(14, 1)) void'(f.pop_back());
                end
                default: begin
                    f.delete();
                    repeat ($urandom_range(6, 1)) begin
                        os_sym_t s;
                        s = '{k: 1'($urandom), data: 8'($urandom)};
                        if (s.k && s.data == COM) s.k = 1'b0;
                        f.push_back(s);
                    end
                end
            endcase
            send(f, int'($urandom_range(3, 0)), 1'b0, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
